// File: rtl/surf_digitize_scheduler_if.sv
// surf_digitize_scheduler_if: command, digitizer handshake and readout-ack signals of the digitize scheduler.
interface surf_digitize_scheduler_if;
   logic        event_id_wr;
   logic        event_id_ok;
   logic [1:0]  event_id_buffer;
   logic [31:0] event_id;
   logic        dig_start;
   logic [1:0]  dig_buffer;
   logic [31:0] dig_event_id;
   logic        dig_done;
   logic        rd_ack;
   logic [1:0]  rd_ack_buffer;
   modport master (
      output event_id_wr, event_id_ok, event_id_buffer, event_id, dig_done, rd_ack, rd_ack_buffer,
      input  dig_start, dig_buffer, dig_event_id
   );
   modport slave (
      input  event_id_wr, event_id_ok, event_id_buffer, event_id, dig_done, rd_ack, rd_ack_buffer,
      output dig_start, dig_buffer, dig_event_id
   );
endinterface

// File: rtl/surf_digitize_scheduler.sv
// surf_digitize_scheduler: queues LAB digitize commands, tracks buffer occupancy, runs one digitize at a time.
// Optional digitize watchdog is enabled by defining SURF_DIG_TIMEOUT_EN.
module surf_digitize_scheduler #(
   parameter int NBUF           = 4,
   parameter int ERRCNT_BITS    = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk33_i,
   input  logic                   rst_n_i,
   input  logic                   clr_all_i,
   surf_digitize_scheduler_if.slave bus,
   output logic [NBUF-1:0]        buf_occupied_o,
   output logic [NBUF-1:0]        buf_ready_o,
   output logic                   busy_o,
   output logic                   overrun_o,
   output logic [ERRCNT_BITS-1:0] sum_err_count_o,
   output logic                   timeout_o
);
`ifdef SURF_DIG_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
   state_t      state;
   logic [1:0]  q_buf [4];
   logic [31:0] q_id [4];
   logic [1:0]  wp, rp;
   logic [2:0]  cnt;
   logic [15:0] tmr;
   logic [NBUF-1:0] rel_m, wr_m, dig_m, occ_rel;
   logic rel, push, pop, done, to;
   // A release only counts for a digitized buffer, and it is applied before judging a same-cycle write.
   always_comb begin
      rel_m   = NBUF'(1) << bus.rd_ack_buffer;
      wr_m    = NBUF'(1) << bus.event_id_buffer;
      dig_m   = NBUF'(1) << bus.dig_buffer;
      rel     = bus.rd_ack && |(buf_ready_o & rel_m);
      occ_rel = rel ? buf_occupied_o & ~rel_m : buf_occupied_o;
      push    = bus.event_id_wr && bus.event_id_ok && !(|(occ_rel & wr_m));
      pop     = state == IDLE && cnt != 3'd0;
      done    = state == WAIT && bus.dig_done;
      to      = TO_EN && state == WAIT && !bus.dig_done && tmr == TO_LIM;
   end
   assign busy_o = state != IDLE;
   always_ff @(posedge clk33_i)
      if (push && !clr_all_i) begin
         q_buf[wp] <= bus.event_id_buffer;
         q_id[wp]  <= bus.event_id;
      end
   always_ff @(posedge clk33_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state            <= IDLE;
         wp               <= '0;
         rp               <= '0;
         cnt              <= '0;
         tmr              <= '0;
         buf_occupied_o   <= '0;
         buf_ready_o      <= '0;
         overrun_o        <= 1'b0;
         sum_err_count_o  <= '0;
         timeout_o        <= 1'b0;
         bus.dig_start    <= 1'b0;
         bus.dig_buffer   <= '0;
         bus.dig_event_id <= '0;
      end else if (clr_all_i) begin
         state            <= IDLE;
         wp               <= '0;
         rp               <= '0;
         cnt              <= '0;
         tmr              <= '0;
         buf_occupied_o   <= '0;
         buf_ready_o      <= '0;
         overrun_o        <= 1'b0;
         sum_err_count_o  <= '0;
         timeout_o        <= 1'b0;
         bus.dig_start    <= 1'b0;
         bus.dig_buffer   <= '0;
         bus.dig_event_id <= '0;
      end else begin
         wp             <= push ? wp + 2'd1 : wp;
         rp             <= pop ? rp + 2'd1 : rp;
         cnt            <= cnt + 3'(push) - 3'(pop);
         buf_occupied_o <= (occ_rel | (push ? wr_m : '0)) & ~(to ? dig_m : '0);
         buf_ready_o    <= (rel ? buf_ready_o & ~rel_m : buf_ready_o) | (done ? dig_m : '0);
         overrun_o      <= overrun_o | (bus.event_id_wr && bus.event_id_ok && !push);
         if (bus.event_id_wr && !bus.event_id_ok && sum_err_count_o != '1)
            sum_err_count_o <= sum_err_count_o + ERRCNT_BITS'(1);
         timeout_o      <= timeout_o | to;
         bus.dig_start  <= 1'b0;
         tmr            <= tmr + 16'd1;
         case (state)
            IDLE: if (pop) begin
               bus.dig_buffer   <= q_buf[rp];
               bus.dig_event_id <= q_id[rp];
               bus.dig_start    <= 1'b1;
               state            <= START;
            end
            START: begin
               tmr   <= '0;
               state <= WAIT;
            end
            WAIT: if (done || to) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_surf_digitize_scheduler.sv
// tb_surf_digitize_scheduler: directed scoreboard bench for the digitize scheduler.
module tb_surf_digitize_scheduler;
`ifdef SURF_DIG_TIMEOUT_EN
   localparam int TO = 100;
`else
   localparam int TO = 65535;
`endif
   typedef struct packed {logic [1:0] b; logic [31:0] id;} ent_t;
   logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
   logic [3:0] occ, rdy;
   logic [7:0] errc;
   logic busy, ovr, tmo;
   int n_vec = 0, n_err = 0;
   ent_t sb [$];
   surf_digitize_scheduler_if bus();
   surf_digitize_scheduler #(.NBUF(4), .ERRCNT_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk33_i(clk), .rst_n_i(rst_n), .clr_all_i(clr), .bus(bus),
      .buf_occupied_o(occ), .buf_ready_o(rdy), .busy_o(busy), .overrun_o(ovr),
      .sum_err_count_o(errc), .timeout_o(tmo)
   );
   always #15 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic wr(input logic ok, input logic [1:0] b, input logic [31:0] id);
      bus.event_id_wr = 1'b1;
      bus.event_id_ok = ok;
      bus.event_id_buffer = b;
      bus.event_id = id;
      tick();
      bus.event_id_wr = 1'b0;
   endtask
   task automatic done_p();
      bus.dig_done = 1'b1;
      tick();
      bus.dig_done = 1'b0;
   endtask
   task automatic ack(input logic [1:0] b);
      bus.rd_ack = 1'b1;
      bus.rd_ack_buffer = b;
      tick();
      bus.rd_ack = 1'b0;
   endtask
   // monitor: every digitize request must match the oldest expected entry
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (bus.dig_start === 1'b1) begin
            chk("start_expected", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("dig_buffer", bus.dig_buffer, e.b);
               chk("dig_event_id", bus.dig_event_id, e.id);
            end
         end
      end
   end
   initial begin
      #3000000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end
   initial begin
      bus.event_id_wr = 0; bus.event_id_ok = 0; bus.event_id_buffer = 0; bus.event_id = 0;
      bus.dig_done = 0; bus.rd_ack = 0; bus.rd_ack_buffer = 0;
      tick(3);
      chk("rst occ", occ, 0);
      chk("rst rdy", rdy, 0);
      chk("rst busy", busy, 0);
      chk("rst ovr", ovr, 0);
      chk("rst errc", errc, 0);
      chk("rst start", bus.dig_start, 0);
      chk("rst tmo", tmo, 0);
      rst_n = 1'b1;
      tick();
      // single event round trip
      sb.push_back({2'd2, 32'h12345678});
      wr(1, 2, 32'h12345678);
      chk("t1 occ", occ, 4'b0100);
      chk("t1 busy before pop", busy, 0);
      tick();
      chk("t1 start latency", bus.dig_start, 1);
      chk("t1 busy", busy, 1);
      tick();
      chk("t1 start one cycle", bus.dig_start, 0);
      tick(3);
      chk("t1 hold buf", bus.dig_buffer, 2);
      ack(2);
      chk("t1 early ack ignored", occ, 4'b0100);
      done_p();
      chk("t1 rdy", rdy, 4'b0100);
      chk("t1 occ after done", occ, 4'b0100);
      chk("t1 idle", busy, 0);
      ack(2);
      chk("t1 occ released", occ, 0);
      chk("t1 rdy released", rdy, 0);
      done_p();
      chk("done outside wait", rdy, 0);
      // four buffers, slow digitizer
      for (int i = 0; i < 4; i++) sb.push_back({2'(i), 32'hA0000000 + i});
      for (int i = 0; i < 4; i++) wr(1, 2'(i), 32'hA0000000 + i);
      tick(5);
      chk("t2 occ", occ, 4'b1111);
      chk("t2 one started", sb.size(), 3);
      for (int k = 0; k < 4; k++) begin
         done_p();
         if (k < 3) begin
            tick();
            chk("t2 restart latency", bus.dig_start, 1);
            tick(4);
         end
      end
      chk("t2 rdy", rdy, 4'b1111);
      chk("t2 ovr", ovr, 0);
      for (int i = 0; i < 4; i++) ack(2'(i));
      chk("t2 occ released", occ, 0);
      // double write to buffer 1
      sb.push_back({2'd1, 32'hB0000001});
      wr(1, 1, 32'hB0000001);
      tick();
      chk("t3 start", bus.dig_start, 1);
      wr(1, 1, 32'hB0000002);
      chk("t3 ovr", ovr, 1);
      tick(3);
      done_p();
      tick(4);
      chk("t3 rdy", rdy, 4'b0010);
      chk("t3 single start", sb.size(), 0);
      ack(1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t3 clr ovr", ovr, 0);
      // checksum failures saturate, then clear with a discarded write
      for (int i = 0; i < 300; i++) wr(0, 2'(i), 32'(i));
      chk("t4 errc sat", errc, 8'hFF);
      chk("t4 occ", occ, 0);
      chk("t4 busy", busy, 0);
      bus.event_id_wr = 1'b1; bus.event_id_ok = 1'b1; bus.event_id_buffer = 0; bus.event_id = 32'hDEAD;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      bus.event_id_wr = 1'b0;
      chk("t4 errc clr", errc, 0);
      chk("t4 clr drops write", occ, 0);
      tick(4);
      chk("t4 still idle", busy, 0);
      // same-cycle release and write on buffer 3
      sb.push_back({2'd3, 32'hC0000001});
      wr(1, 3, 32'hC0000001);
      tick();
      chk("t5 start", bus.dig_start, 1);
      tick(2);
      done_p();
      chk("t5 rdy", rdy, 4'b1000);
      sb.push_back({2'd3, 32'hC0000002});
      bus.rd_ack = 1'b1; bus.rd_ack_buffer = 3;
      bus.event_id_wr = 1'b1; bus.event_id_ok = 1'b1; bus.event_id_buffer = 3; bus.event_id = 32'hC0000002;
      tick();
      bus.rd_ack = 1'b0;
      bus.event_id_wr = 1'b0;
      chk("t5 ovr", ovr, 0);
      chk("t5 occ", occ, 4'b1000);
      chk("t5 rdy cleared", rdy, 0);
      tick();
      chk("t5 restart", bus.dig_start, 1);
      tick(2);
      done_p();
      ack(3);
      chk("t5 occ released", occ, 0);
      // clear while digitizing discards the in-flight done
      sb.push_back({2'd0, 32'hD0000001});
      wr(1, 0, 32'hD0000001);
      tick(3);
      clr = 1'b1;
      bus.dig_done = 1'b1;
      tick();
      clr = 1'b0;
      bus.dig_done = 1'b0;
      chk("clr busy", busy, 0);
      chk("clr rdy", rdy, 0);
      chk("clr occ", occ, 0);
`ifdef SURF_DIG_TIMEOUT_EN
      sb.push_back({2'd0, 32'hE0000000});
      sb.push_back({2'd1, 32'hE0000001});
      wr(1, 0, 32'hE0000000);
      wr(1, 1, 32'hE0000001);
      tick(100);
      chk("t6 no timeout yet", tmo, 0);
      tick();
      chk("t6 timeout", tmo, 1);
      chk("t6 occ", occ, 4'b0010);
      chk("t6 rdy", rdy, 0);
      tick();
      chk("t6 next start", bus.dig_start, 1);
      tick(2);
      done_p();
      ack(1);
`else
      tick(20);
      chk("timeout tied", tmo, 0);
`endif
      tick(3);
      chk("sb drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/surf_digitize_scheduler.md
Name: surf_digitize_scheduler

Overview:
Sequences LAB digitization on the SURF from validated commands delivered by the serial command receiver (event ID, LAB buffer, checksum flag, write strobe). Tracks occupancy of the 4 LAB buffers, queues accepted events in order, and issues one digitize request at a time to the digitizer with a start/done handshake. Releases buffers on readout acknowledge and reports overrun and checksum errors to the housekeeping registers.

Parameters:
NBUF, 4, number of LAB buffers (fixed at 4; 2-bit buffer IDs).
ERRCNT_BITS, 8, width of the saturating checksum-error counter.
TIMEOUT_CYCLES, 65535, watchdog limit on the digitize handshake, in clk33_i cycles (used only with the optional feature).

Ports:
clk33_i  in  1  33 MHz system clock
rst_n_i  in  1  asynchronous reset, active-low
clr_all_i  in  1  synchronous flush of queue, occupancy and errors
event_id_wr_i  in  1  one-cycle strobe: command complete
event_id_ok_i  in  1  checksum good, valid while event_id_wr_i is high
event_id_buffer_i  in  2  LAB buffer for this event
event_id_i  in  32  event ID
dig_start_o  out  1  one-cycle digitize request
dig_buffer_o  out  2  buffer to digitize, held from dig_start_o until done
dig_event_id_o  out  32  event ID, held with dig_buffer_o
dig_done_i  in  1  one-cycle strobe: digitizer finished
rd_ack_i  in  1  one-cycle strobe: readout of rd_ack_buffer_i complete
rd_ack_buffer_i  in  2  buffer being released
buf_occupied_o  out  4  bit n set while buffer n is queued, digitizing or awaiting readout
buf_ready_o  out  4  bit n set when buffer n is digitized and awaiting readout
busy_o  out  1  scheduler not IDLE
overrun_o  out  1  sticky: write to an occupied buffer
sum_err_count_o  out  ERRCNT_BITS  checksum failures, saturating
timeout_o  out  1  sticky watchdog flag (0 when feature is compiled out)

Behaviour:
- Reset (rst_n_i low, async): all outputs 0, queue empty, state IDLE.
- Queue: 4-entry FIFO of {buffer[1:0], event_id[31:0]} with 2-bit read/write pointers and a 3-bit count. It cannot overflow because at most 4 buffers can be occupied.
- Write acceptance (event_id_wr_i high):
  - ok=0: increment sum_err_count_o, saturating at all-ones. No other effect.
  - ok=1 and buffer free: push the entry; set buf_occupied_o[b] on the next cycle.
  - ok=1 and buffer occupied: drop the entry and set overrun_o.
- Release: rd_ack_i clears buf_occupied_o[b] and buf_ready_o[b]. A release is ignored if buf_ready_o[b]=0, so acks for buffers that are still queued or digitizing are discarded.
- Same cycle rd_ack_i and event_id_wr_i on the same buffer: the release is evaluated first, so the write is accepted with no overrun.
- FSM states:
  - IDLE: if count>0, pop the head into dig_buffer_o/dig_event_id_o and go to START.
  - START: dig_start_o=1 for exactly one cycle, then go to WAIT.
  - WAIT: on dig_done_i, set buf_ready_o[dig_buffer_o] and go to IDLE.
- Latency: a write into an empty queue while IDLE gives dig_start_o 2 cycles after event_id_wr_i. After dig_done_i, the next queued entry gives dig_start_o 2 cycles later.
- dig_done_i is ignored outside WAIT.
- Push and pop in the same cycle are legal; count is unchanged.
- clr_all_i (synchronous, highest priority below reset):
  - empties the queue;
  - clears buf_occupied_o, buf_ready_o, overrun_o, sum_err_count_o and timeout_o;
  - forces IDLE;
  - an in-flight dig_done_i is discarded;
  - writes in the same cycle are discarded.

Optional Feature:
SURF_DIG_TIMEOUT_EN:
- Defined: a 16-bit counter runs in WAIT and clears on entry. If it reaches TIMEOUT_CYCLES without dig_done_i, the FSM sets timeout_o, clears buf_occupied_o[dig_buffer_o] without setting ready, and returns to IDLE.
- Not defined: WAIT waits indefinitely, and timeout_o is tied to 0.

Test Plan:
1. Reset, then write ok=1 buf=2 id=0x12345678 → dig_start_o 2 cycles later with dig_buffer_o=2 and dig_event_id_o=0x12345678; buf_occupied_o=0100. After dig_done_i, buf_ready_o=0100. After rd_ack_i buf=2, both are 0000.
2. Four writes to buffers 0,1,2,3 on consecutive cycles while the digitizer is slow → four dig_start_o in order 0,1,2,3, each only after the prior dig_done_i; overrun_o stays 0.
3. Write buf=1 twice before readout → second write dropped, overrun_o=1, exactly one dig_start_o.
4. 300 writes with ok=0 → sum_err_count_o=255, no dig_start_o. Then clr_all_i → count=0.
5. Buffer 3 ready, then rd_ack_i buf=3 and a write buf=3 in the same cycle → write accepted, overrun_o=0, new dig_start_o for buffer 3.
6. With SURF_DIG_TIMEOUT_EN and TIMEOUT_CYCLES=100, no dig_done_i → at cycle 100 in WAIT, timeout_o=1, the buffer is freed, the FSM is IDLE, and the next queued entry starts.
